// File: rtl/sqrtln_coef_lookup.sv
// Segment-coefficient lookup for the sqrt(-ln U) approximation: normalises a uniform sample
// into an exact double (delta) and fetches the cubic coefficients of its segment.
module sqrtln_coef_lookup (
    input  logic        clk,
    input  logic        rst,
    input  logic        pushin,
    input  logic [31:0] u,
    input  logic        cfg_we,
    input  logic [7:0]  cfg_addr,
    input  logic [63:0] cfg_data,
    output logic        pushout,
    output logic [63:0] A,
    output logic [63:0] B,
    output logic [63:0] C,
    output logic [63:0] D,
    output logic [63:0] delta
);

    localparam logic [5:0] IdxTail = 6'd60;

    // Flat table addressed directly by {idx, sel}; deliberately not reset.
    logic [63:0] coef_tbl [256];

    logic        valid_s1;
    logic [31:0] u_s1;

    logic        valid_s2;
    logic [5:0]  idx_s2;
    logic [63:0] delta_s2;

    logic [4:0]  lz;
    logic [30:0] norm;
    logic [5:0]  idx_d;
    logic [63:0] delta_d;

    function automatic logic [4:0] clz32(input logic [31:0] x);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) n = 5'(31 - i);
        end
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (cfg_we) coef_tbl[cfg_addr] <= cfg_data;
    end

    // Stage 1: capture the sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_s1 <= 1'b0;
            u_s1     <= 32'd0;
        end else begin
            valid_s1 <= pushin;
            u_s1     <= u;
        end
    end

    // Stage 2 combinational: normalise so the leading one sits at bit 31 and is dropped.
    always_comb begin
        lz      = clz32(u_s1);
        norm    = 31'(u_s1 << lz);
        idx_d   = IdxTail;
        delta_d = 64'd0;
        if (u_s1 != 32'd0) begin
            delta_d = {1'b0, 11'd1022 - {6'd0, lz}, norm, 21'd0};
            if (lz <= 5'd14) idx_d = {lz[3:0], norm[30:29]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_s2 <= 1'b0;
            idx_s2   <= 6'd0;
            delta_s2 <= 64'd0;
        end else begin
            valid_s2 <= valid_s1;
            idx_s2   <= idx_d;
            delta_s2 <= delta_d;
        end
    end

    // Stage 3: a same-edge cfg write is not yet visible here, so collisions return old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pushout <= 1'b0;
            A       <= 64'd0;
            B       <= 64'd0;
            C       <= 64'd0;
            D       <= 64'd0;
            delta   <= 64'd0;
        end else begin
            pushout <= valid_s2;
            if (valid_s2) begin
                A     <= coef_tbl[{idx_s2, 2'd0}];
                B     <= coef_tbl[{idx_s2, 2'd1}];
                C     <= coef_tbl[{idx_s2, 2'd2}];
                D     <= coef_tbl[{idx_s2, 2'd3}];
                delta <= delta_s2;
            end
        end
    end

endmodule

// File: tb/tb_sqrtln_coef_lookup.sv
// Directed self-checking bench for sqrtln_coef_lookup.
module tb_sqrtln_coef_lookup;

    logic        clk = 1'b0;
    logic        rst;
    logic        pushin;
    logic [31:0] u;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [63:0] cfg_data;
    logic        pushout;
    logic [63:0] A, B, C, D, delta;

    int n_checks = 0;
    int n_fail   = 0;

    sqrtln_coef_lookup dut (
        .clk      (clk),
        .rst      (rst),
        .pushin   (pushin),
        .u        (u),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .pushout  (pushout),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .delta    (delta)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] coef(input int k, input int sel);
        return $realtobits(real'(k + 100 * sel));
    endfunction

    function automatic int lead_pos(input logic [31:0] x);
        int p;
        p = -1;
        for (int i = 31; i >= 0; i--) begin
            if (x[i] && p < 0) p = i;
        end
        return p;
    endfunction

    function automatic int model_idx(input logic [31:0] x);
        int p;
        p = lead_pos(x);
        if (p < 17) return 60;
        return (31 - p) * 4 + int'((x >> (p - 2)) & 32'd3);
    endfunction

    function automatic logic [63:0] model_delta(input logic [31:0] x);
        int p;
        logic [63:0] m;
        p = lead_pos(x);
        if (p < 0) return 64'd0;
        m = 64'(x) & ((64'd1 << p) - 64'd1);
        m = m << (52 - p);
        return {1'b0, 11'(1022 - (31 - p)), m[51:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (pushout !== 1'b0) begin n_fail++; $display("FAIL reset_pushout got %0b want 0", pushout); end
        n_checks++; if (A !== 64'd0) begin n_fail++; $display("FAIL reset_A got %h want 0", A); end
        n_checks++; if (B !== 64'd0) begin n_fail++; $display("FAIL reset_B got %h want 0", B); end
        n_checks++; if (C !== 64'd0) begin n_fail++; $display("FAIL reset_C got %h want 0", C); end
        n_checks++; if (D !== 64'd0) begin n_fail++; $display("FAIL reset_D got %h want 0", D); end
        n_checks++; if (delta !== 64'd0) begin n_fail++; $display("FAIL reset_delta got %h want 0", delta); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_table();
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            cfg_we   = 1'b1;
            cfg_addr = 8'(a);
            cfg_data = coef(a / 4, a % 4);
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] vu   [7] = '{32'h8000_0000, 32'hC000_0000, 32'h0000_0001, 32'h0000_0000,
                                  32'h0001_0000, 32'h0003_0000, 32'h5A00_0000};
        int          vidx [7] = '{0, 2, 60, 60, 60, 58, 5};
        logic [63:0] vdel [7] = '{64'h3FE0_0000_0000_0000, 64'h3FE8_0000_0000_0000,
                                  64'h3DF0_0000_0000_0000, 64'h0,
                                  64'h3EF0_0000_0000_0000, 64'h3F08_0000_0000_0000,
                                  64'h3FD6_8000_0000_0000};
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            pushin = 1'b1;
            u      = vu[v];
            @(negedge clk);
            pushin = 1'b0;
            u      = 32'hDEAD_BEEF;
            @(negedge clk);
            n_checks++; if (pushout !== 1'b0) begin n_fail++; $display("FAIL dir_early_pushout v%0d got %0b want 0", v, pushout); end
            @(negedge clk);
            n_checks++; if (pushout !== 1'b1) begin n_fail++; $display("FAIL dir_pushout v%0d got %0b want 1", v, pushout); end
            n_checks++; if (A !== coef(vidx[v], 0)) begin n_fail++; $display("FAIL dir_A v%0d got %h want %h", v, A, coef(vidx[v], 0)); end
            n_checks++; if (B !== coef(vidx[v], 1)) begin n_fail++; $display("FAIL dir_B v%0d got %h want %h", v, B, coef(vidx[v], 1)); end
            n_checks++; if (C !== coef(vidx[v], 2)) begin n_fail++; $display("FAIL dir_C v%0d got %h want %h", v, C, coef(vidx[v], 2)); end
            n_checks++; if (D !== coef(vidx[v], 3)) begin n_fail++; $display("FAIL dir_D v%0d got %h want %h", v, D, coef(vidx[v], 3)); end
            n_checks++; if (delta !== vdel[v]) begin n_fail++; $display("FAIL dir_delta v%0d got %h want %h", v, delta, vdel[v]); end
            @(negedge clk);
            n_checks++; if (pushout !== 1'b0) begin n_fail++; $display("FAIL dir_pulse v%0d got %0b want 0", v, pushout); end
            n_checks++; if (delta !== vdel[v]) begin n_fail++; $display("FAIL dir_hold v%0d got %h want %h", v, delta, vdel[v]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] su [11] = '{32'h8000_0000, 32'hC000_0000, 32'h4000_0000, 32'h2345_6789,
                                 32'h0001_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h00F0_0001,
                                 32'h0, 32'h0, 32'h3000_0000};
        logic        pv [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1};
        logic [31:0] last_u;
        last_u = 32'h0003_0000;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            if (t >= 3) begin
                n_checks++;
                if (pushout !== pv[t-3]) begin
                    n_fail++;
                    $display("FAIL b2b_pushout slot%0d got %0b want %0b", t - 3, pushout, pv[t-3]);
                end
                if (pv[t-3]) last_u = su[t-3];
                n_checks++;
                if (A !== coef(model_idx(last_u), 0)) begin
                    n_fail++;
                    $display("FAIL b2b_A slot%0d got %h want %h", t - 3, A, coef(model_idx(last_u), 0));
                end
                n_checks++;
                if (D !== coef(model_idx(last_u), 3)) begin
                    n_fail++;
                    $display("FAIL b2b_D slot%0d got %h want %h", t - 3, D, coef(model_idx(last_u), 3));
                end
                n_checks++;
                if (delta !== model_delta(last_u)) begin
                    n_fail++;
                    $display("FAIL b2b_delta slot%0d got %h want %h", t - 3, delta, model_delta(last_u));
                end
            end
            if (t < 11) begin
                pushin = pv[t];
                u      = su[t];
            end else begin
                pushin = 1'b0;
            end
        end
    endtask

    task automatic test_reset_in_flight();
        @(negedge clk);
        pushin = 1'b1;
        u      = 32'hC000_0000;
        @(negedge clk);
        u      = 32'h4000_0000;
        @(negedge clk);
        pushin = 1'b0;
        rst    = 1'b1;
        #1;
        n_checks++; if (pushout !== 1'b0) begin n_fail++; $display("FAIL rif_pushout got %0b want 0", pushout); end
        n_checks++; if (A !== 64'd0) begin n_fail++; $display("FAIL rif_A got %h want 0", A); end
        n_checks++; if (B !== 64'd0) begin n_fail++; $display("FAIL rif_B got %h want 0", B); end
        n_checks++; if (C !== 64'd0) begin n_fail++; $display("FAIL rif_C got %h want 0", C); end
        n_checks++; if (D !== 64'd0) begin n_fail++; $display("FAIL rif_D got %h want 0", D); end
        n_checks++; if (delta !== 64'd0) begin n_fail++; $display("FAIL rif_delta got %h want 0", delta); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (pushout !== 1'b0) begin n_fail++; $display("FAIL rif_drop cyc%0d got %0b want 0", i, pushout); end
        end
        pushin = 1'b1;
        u      = 32'h8000_0000;
        @(negedge clk);
        pushin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (pushout !== 1'b1) begin n_fail++; $display("FAIL rif_after_pushout got %0b want 1", pushout); end
        n_checks++; if (B !== coef(0, 1)) begin n_fail++; $display("FAIL rif_after_B got %h want %h", B, coef(0, 1)); end
        n_checks++; if (D !== coef(0, 3)) begin n_fail++; $display("FAIL rif_after_D got %h want %h", D, coef(0, 3)); end
        n_checks++; if (delta !== 64'h3FE0_0000_0000_0000) begin n_fail++; $display("FAIL rif_after_delta got %h want 3fe0000000000000", delta); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        pushin = 1'b1;
        u      = 32'h8000_0000;
        @(negedge clk);
        pushin = 1'b0;
        @(negedge clk);
        // Write lands on the same edge that stage 3 reads entry 0.
        cfg_we   = 1'b1;
        cfg_addr = 8'h00;
        cfg_data = 64'h3FF8_0000_0000_0000;
        @(negedge clk);
        n_checks++; if (pushout !== 1'b1) begin n_fail++; $display("FAIL col_pushout got %0b want 1", pushout); end
        n_checks++; if (A !== coef(0, 0)) begin n_fail++; $display("FAIL col_old_A got %h want %h", A, coef(0, 0)); end
        cfg_we = 1'b0;
        pushin = 1'b1;
        u      = 32'h8000_0000;
        @(negedge clk);
        pushin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (pushout !== 1'b1) begin n_fail++; $display("FAIL col_next_pushout got %0b want 1", pushout); end
        n_checks++; if (A !== 64'h3FF8_0000_0000_0000) begin n_fail++; $display("FAIL col_new_A got %h want 3ff8000000000000", A); end
        n_checks++; if (B !== coef(0, 1)) begin n_fail++; $display("FAIL col_B got %h want %h", B, coef(0, 1)); end
    endtask

    initial begin
        rst      = 1'b1;
        pushin   = 1'b0;
        u        = 32'd0;
        cfg_we   = 1'b0;
        cfg_addr = 8'd0;
        cfg_data = 64'd0;
        test_reset();
        load_table();
        test_directed();
        test_back_to_back();
        test_reset_in_flight();
        test_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
